sha256_w_sequencer: RTL and testbench
=====================================

# sha256_w_sequencer

Iterative SHA-256 message-schedule sequencer. It accepts one 512-bit padded message block and streams the 64 schedule words W0..W63 one per handshake to the compression-round engine. It uses a 16-word sliding window and a single shared σ0/σ1/adder datapath, replacing the fully unrolled 64-word combinational schedule in area-constrained builds. It sits between the block padder/loader and the round controller.

## Interface
- `WORD_W`, 32: schedule word width; only 32 is supported.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `blk_valid` in 1: a message block is offered.
- `blk_ready` out 1: the sequencer can accept a block.
- `blk_data` in 512: the block; word M0 is in [511:480], M15 in [31:0].
- `abort` in 1: synchronous cancel of the current block.
- `w_valid` out 1: `w_data` holds a schedule word.
- `w_ready` in 1: the consumer accepts the word.
- `w_data` out 32: schedule word W[w_idx].
- `w_idx` out 6: round index t, 0..63.
- `w_last` out 1: high together with `w_valid` when t = 63.
- `busy` out 1: high in STREAM.

## Operation
- There are two states: IDLE and STREAM. The block holds a 16×32 window `win[0..15]` and a 6-bit counter `t`.
- **IDLE**
  - `blk_ready = ~abort`; `w_valid = 0`.
  - On `blk_valid & blk_ready`: load `win[i] <= M_i`, set `t <= 0`, go to STREAM.
- **STREAM**
  - `w_valid = 1`, `w_data = win[0]`, `w_idx = t`, `blk_ready = 0`.
  - On `w_valid & w_ready`:
    - `win[i] <= win[i+1]` for i = 0..14.
    - `win[15] <= σ1(win[14]) + win[9] + σ0(win[1]) + win[0]`, which is W(t+16).
    - `t <= t + 1`.
  - If t = 63 at acceptance, go to IDLE.
  - Values shifted in during t ≥ 48 are never output; their value is don't-care.
- **Stall:** with `w_ready` low, the window, `t`, and all outputs hold stable. `w_valid` never drops without a handshake, except on abort or reset.
- **Abort:** `abort` high in STREAM sends the state to IDLE on the next edge. Abort takes priority over a simultaneous `w` handshake: no shift occurs and `t <= 0`. Abort in IDLE blocks acceptance that cycle and has no other effect.
- **Arithmetic:** all additions are modulo 2^32, with carries discarded.
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- There is exactly one σ0, one σ1, and one 4-input adder. The window is never recomputed from the original block.
- `t` never wraps: the exit to IDLE happens at the t = 63 handshake.

## Timing
- **Reset values** (asynchronous assert, synchronous deassert handled at top level):
  - state IDLE, `win` all zero, `t` = 0.
  - Outputs: `blk_ready` = 1, `w_valid` = 0, `w_data` = 0, `w_idx` = 0, `w_last` = 0, `busy` = 0.
- Reset mid-stream discards the block immediately, with no further `w_valid`.
- **Load latency:** a block accepted at edge k gives `w_valid` = 1 with W0 from the cycle after edge k.
- `w_data`, `w_idx`, `w_valid`, `w_last`, and `busy` are driven from registers. The only combinational output is `blk_ready`, and it depends only on state and `abort`.
- **Throughput:** one word per cycle while `w_ready` = 1. W63 accepted at edge k+64 gives `blk_ready` = 1 after that edge. The minimum block-to-block period is 65 cycles.
- The critical path is σ1/σ0 plus the 4-operand 32-bit add into `win[15]`.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-stream at t = 20 → all outputs take their reset values within the same cycle, and the next block is accepted normally.
- **"abc" block** (M0 = 0x61626380, M1..M14 = 0, M15 = 0x00000018), with `w_ready` tied to 1:
  - W16 = 0x61626380, W17 = 0x000F0000, W18 = 0x7DA86405.
  - All 64 words match the software model.
  - `w_last` is high only at t = 63.
  - `blk_ready` rises 65 cycles after acceptance.
- **Random `w_ready` backpressure** (50%), random blocks ×100 → word sequence identical to the model, and outputs stable during every stall.
- **Abort at t = 5** with `w_ready` = 1 simultaneously → no t = 6 output, IDLE next cycle, `blk_ready` = 1. A subsequent block streams W0 correctly.
- **`blk_valid` held high during STREAM** with a different block → not accepted until after W63. Back-to-back blocks give a 65-cycle period, each with correct words.
- **All-ones block** (every M = 0xFFFFFFFF) → adder wraps modulo 2^32 and matches the model, e.g. W16 = σ1(0xFFFFFFFF) + 0xFFFFFFFF + σ0(0xFFFFFFFF) + 0xFFFFFFFF.

Source files
------------

// File: rtl/sha256_w_sequencer.sv
// SHA-256 message-schedule sequencer.
// Loads one 512-bit block into a 16-word sliding window and streams W0..W63,
// one word per handshake, extending the window with a single shared
// sigma0/sigma1/4-input-adder datapath.
module sha256_w_sequencer #(
   parameter int WORD_W = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  blk_valid,
   output logic                  blk_ready,
   input  logic [16*WORD_W-1:0]  blk_data,
   input  logic                  abort,
   output logic                  w_valid,
   input  logic                  w_ready,
   output logic [WORD_W-1:0]     w_data,
   output logic [5:0]            w_idx,
   output logic                  w_last,
   output logic                  busy
);

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_STREAM = 1'b1
   } state_e;

   localparam logic [5:0] LAST_IDX = 6'd63;

   state_e              state_q, state_d;
   logic [WORD_W-1:0]   win_q [16];
   logic [WORD_W-1:0]   win_d [16];
   logic [5:0]          t_q, t_d;
   logic                w_valid_q, w_valid_d;
   logic                w_last_q, w_last_d;
   logic                busy_q, busy_d;

   logic                load_en;
   logic                shift_en;
   logic                abort_en;
   logic [WORD_W-1:0]   w_new;

   // Small sigma functions of the SHA-256 schedule (32-bit words only)
   function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: abort wins over a simultaneous word handshake
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (blk_valid && !abort) begin
               state_d = S_STREAM;
            end
         end
         S_STREAM: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (w_ready && (t_q == LAST_IDX)) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output/control decode: blk_ready is the only combinational output
   always_comb begin
      blk_ready = 1'b0;
      load_en   = 1'b0;
      shift_en  = 1'b0;
      abort_en  = 1'b0;
      case (state_q)
         S_IDLE: begin
            blk_ready = !abort;
            load_en   = blk_valid && !abort;
         end
         S_STREAM: begin
            abort_en = abort;
            shift_en = w_ready && !abort;
         end
         default: ;
      endcase
   end

   // Shared schedule datapath: W(t+16) from the current window
   assign w_new = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

   // Window / counter / registered-output next values
   always_comb begin
      for (int i = 0; i < 16; i++) begin
         win_d[i] = win_q[i];
      end
      t_d = t_q;
      if (load_en) begin
         for (int i = 0; i < 16; i++) begin
            win_d[i] = blk_data[(15-i)*WORD_W +: WORD_W];
         end
         t_d = 6'd0;
      end else if (shift_en) begin
         for (int i = 0; i < 15; i++) begin
            win_d[i] = win_q[i+1];
         end
         win_d[15] = w_new;
         // Leaving STREAM at t = 63 returns the counter to 0 instead of wrapping
         t_d = (t_q == LAST_IDX) ? 6'd0 : t_q + 6'd1;
      end else if (abort_en) begin
         t_d = 6'd0;
      end
      w_valid_d = (state_d == S_STREAM);
      busy_d    = (state_d == S_STREAM);
      w_last_d  = (state_d == S_STREAM) && (t_d == LAST_IDX);
   end

   // Window, round counter and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) begin
            win_q[i] <= '0;
         end
         t_q       <= 6'd0;
         w_valid_q <= 1'b0;
         w_last_q  <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         for (int i = 0; i < 16; i++) begin
            win_q[i] <= win_d[i];
         end
         t_q       <= t_d;
         w_valid_q <= w_valid_d;
         w_last_q  <= w_last_d;
         busy_q    <= busy_d;
      end
   end

   assign w_data  = win_q[0];
   assign w_idx   = t_q;
   assign w_valid = w_valid_q;
   assign w_last  = w_last_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_sha256_w_sequencer.sv
// Scoreboard bench for sha256_w_sequencer.
module tb_sha256_w_sequencer;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         blk_valid;
   logic         blk_ready;
   logic [511:0] blk_data;
   logic         abort;
   logic         w_valid;
   logic         w_ready;
   logic [31:0]  w_data;
   logic [5:0]   w_idx;
   logic         w_last;
   logic         busy;

   always #5 clk = ~clk;

   sha256_w_sequencer #(.WORD_W(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready),
      .blk_data  (blk_data),
      .abort     (abort),
      .w_valid   (w_valid),
      .w_ready   (w_ready),
      .w_data    (w_data),
      .w_idx     (w_idx),
      .w_last    (w_last),
      .busy      (busy)
   );

   typedef struct packed {
      logic [31:0] d;
      logic [5:0]  i;
      logic        l;
   } exp_t;

   exp_t        sb[$];
   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          acc_cyc = -1;
   logic [31:0] obs [64];
   logic        stall_pend;
   logic [31:0] sn_d;
   logic [5:0]  sn_i;
   logic        sn_l;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      logic [63:0] xx;
      xx = {x, x} >> n;
      return xx[31:0];
   endfunction

   function automatic logic [31:0] m_s0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] m_s1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   task automatic push_block(input logic [511:0] b);
      logic [31:0] w [64];
      exp_t e;
      for (int i = 0; i < 16; i++) w[i] = b[511-32*i -: 32];
      for (int i = 16; i < 64; i++) w[i] = m_s1(w[i-2]) + w[i-7] + m_s0(w[i-15]) + w[i-16];
      for (int i = 0; i < 64; i++) begin
         e.d = w[i];
         e.i = i[5:0];
         e.l = (i == 63);
         sb.push_back(e);
      end
   endtask

   // One clock cycle: inputs already driven just after a negedge
   task automatic tick();
      exp_t e;
      #1;
      if (blk_valid && blk_ready) begin
         push_block(blk_data);
         acc_cyc = cyc;
      end
      if (w_valid && abort) begin
         sb.delete();
      end else if (w_valid && w_ready) begin
         if (sb.size() == 0) begin
            chk("spurious_w_valid", w_valid, 1'b0);
         end else begin
            e = sb.pop_front();
            chk("w_data", w_data, e.d);
            chk("w_idx", w_idx, e.i);
            chk("w_last", w_last, e.l);
            chk("busy", busy, 1'b1);
            obs[w_idx] = w_data;
         end
      end
      stall_pend = w_valid && !w_ready && !abort;
      sn_d = w_data;
      sn_i = w_idx;
      sn_l = w_last;
      @(negedge clk);
      cyc++;
      if (stall_pend) begin
         chk("stall_valid", w_valid, 1'b1);
         chk("stall_data", w_data, sn_d);
         chk("stall_idx", w_idx, sn_i);
         chk("stall_last", w_last, sn_l);
      end
   endtask

   task automatic run_block(input logic [511:0] b, input int pct);
      int n;
      n = 0;
      acc_cyc = -1;
      blk_data = b;
      blk_valid = 1'b1;
      abort = 1'b0;
      while (acc_cyc < 0 && n < 300) begin
         w_ready = ($urandom_range(99) < pct);
         tick();
         n++;
      end
      blk_valid = 1'b0;
      while (sb.size() != 0 && n < 3000) begin
         w_ready = ($urandom_range(99) < pct);
         tick();
         n++;
      end
      chk("run_timeout", {31'd0, (n >= 3000) || (acc_cyc < 0)}, 0);
   endtask

   function automatic logic [511:0] rnd_block();
      logic [511:0] b;
      for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
      return b;
   endfunction

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [511:0] abc;
      logic [511:0] b1;
      logic [511:0] b2;
      int a1;
      int a2;
      int rc;
      int k;

      rst_n = 1'b0;
      blk_valid = 1'b0;
      abort = 1'b0;
      w_ready = 1'b0;
      blk_data = '0;
      #1;
      chk("rst_blk_ready", blk_ready, 1'b1);
      chk("rst_w_valid", w_valid, 1'b0);
      chk("rst_w_data", w_data, 32'd0);
      chk("rst_w_idx", w_idx, 6'd0);
      chk("rst_w_last", w_last, 1'b0);
      chk("rst_busy", busy, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // "abc" block, w_ready held high, block-to-idle latency
      abc = '0;
      abc[511:480] = 32'h61626380;
      abc[31:0] = 32'h00000018;
      blk_data = abc;
      blk_valid = 1'b1;
      w_ready = 1'b1;
      acc_cyc = -1;
      tick();
      blk_valid = 1'b0;
      chk("abc_accept", {31'd0, acc_cyc >= 0}, 1);
      rc = -1;
      k = 0;
      while (rc < 0 && k < 200) begin
         tick();
         k++;
         if (blk_ready) rc = cyc - acc_cyc;
      end
      chk("abc_ready_latency", rc, 65);
      chk("abc_W16", obs[16], 32'h61626380);
      chk("abc_W17", obs[17], 32'h000F0000);
      chk("abc_W18", obs[18], 32'h7DA86405);
      chk("abc_drained", sb.size(), 0);

      // Abort in IDLE blocks acceptance
      blk_data = rnd_block();
      blk_valid = 1'b1;
      abort = 1'b1;
      #1;
      chk("idle_abort_ready", blk_ready, 1'b0);
      tick();
      abort = 1'b0;
      blk_valid = 1'b0;
      #1;
      chk("idle_abort_no_load", w_valid, 1'b0);
      @(negedge clk);

      // Abort at t = 5 together with w_ready
      blk_data = rnd_block();
      blk_valid = 1'b1;
      w_ready = 1'b1;
      acc_cyc = -1;
      k = 0;
      while (acc_cyc < 0 && k < 10) begin
         tick();
         k++;
      end
      blk_valid = 1'b0;
      k = 0;
      abort = 1'b0;
      while (!abort && k < 100) begin
         abort = w_valid && (w_idx == 6'd5);
         tick();
         k++;
      end
      abort = 1'b0;
      #1;
      chk("abort_w_valid", w_valid, 1'b0);
      chk("abort_blk_ready", blk_ready, 1'b1);
      chk("abort_busy", busy, 1'b0);
      chk("abort_idx", w_idx, 6'd0);
      @(negedge clk);
      run_block(rnd_block(), 100);

      // Back-to-back: second block offered during the first stream
      b1 = rnd_block();
      b2 = rnd_block();
      blk_data = b1;
      blk_valid = 1'b1;
      w_ready = 1'b1;
      acc_cyc = -1;
      k = 0;
      while (acc_cyc < 0 && k < 10) begin
         tick();
         k++;
      end
      a1 = acc_cyc;
      blk_data = b2;
      acc_cyc = -1;
      k = 0;
      while (acc_cyc < 0 && k < 200) begin
         tick();
         k++;
      end
      a2 = acc_cyc;
      blk_valid = 1'b0;
      chk("b2b_period", a2 - a1, 65);
      k = 0;
      while (sb.size() != 0 && k < 200) begin
         tick();
         k++;
      end
      chk("b2b_drained", sb.size(), 0);

      // All-ones block: modular wrap in the adder
      run_block({16{32'hFFFFFFFF}}, 100);
      chk("ones_W16", obs[16], 32'h203FFFFC);

      // Asynchronous reset at t = 20
      blk_data = rnd_block();
      blk_valid = 1'b1;
      w_ready = 1'b1;
      acc_cyc = -1;
      tick();
      blk_valid = 1'b0;
      k = 0;
      while (!(w_valid && w_idx == 6'd20) && k < 100) begin
         tick();
         k++;
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk("mrst_blk_ready", blk_ready, 1'b1);
      chk("mrst_w_valid", w_valid, 1'b0);
      chk("mrst_w_data", w_data, 32'd0);
      chk("mrst_w_idx", w_idx, 6'd0);
      chk("mrst_w_last", w_last, 1'b0);
      chk("mrst_busy", busy, 1'b0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("mrst_stays_idle", w_valid, 1'b0);
      @(negedge clk);
      run_block(rnd_block(), 100);

      // Random blocks with 50% backpressure
      for (int n = 0; n < 100; n++) begin
         run_block(rnd_block(), 50);
      end

      chk("final_sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
